regfile_wb_queue: RTL

//  Write-side producer for registerfile: buffers writeback requests (rd, data) from the execute/load stages
//  in a small FIFO and drains one per cycle onto the register file write port (rd, writedata, regwrite).

---
 rtl/regfile_wb_queue_pkg.sv | 18 +
 rtl/regfile_wb_queue_if.sv | 38 +++
 rtl/regfile_wb_queue_fifo.sv | 86 ++++++++
 rtl/regfile_wb_queue.sv | 125 ++++++++++++
 4 files changed

// File: rtl/regfile_wb_queue_pkg.sv
// rtl/regfile_wb_queue_pkg.sv - shared widths, x0 constant and queue entry type for regfile_wb_queue
package regfile_wb_queue_pkg;

  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 4;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;

  localparam logic [AW-1:0] REG_ZERO = '0;

  // One queued writeback: destination register plus the value to write.
  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wb_queue_if.sv
// rtl/regfile_wb_queue_if.sv - writeback request, register-file write port and hazard lookup bundle
import regfile_wb_queue_pkg::*;

interface regfile_wb_queue_if;
  // writeback request side
  logic            invalid;
  logic            inready;
  logic [AW-1:0]   inrd;
  logic [XLEN-1:0] indata;
  // drain control
  logic            wrstall;
  logic            flush;
  // register file write port
  logic [AW-1:0]   rd;
  logic [XLEN-1:0] writedata;
  logic            regwrite;
  // decode hazard lookup
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic            busy1;
  logic            busy2;
  logic            fwdvalid1;
  logic            fwdvalid2;
  logic [XLEN-1:0] fwddata1;
  logic [XLEN-1:0] fwddata2;

  modport master (
    output invalid, inrd, indata, wrstall, flush, rs1, rs2,
    input  inready, rd, writedata, regwrite, busy1, busy2,
           fwdvalid1, fwdvalid2, fwddata1, fwddata2
  );

  modport slave (
    input  invalid, inrd, indata, wrstall, flush, rs1, rs2,
    output inready, rd, writedata, regwrite, busy1, busy2,
           fwdvalid1, fwdvalid2, fwddata1, fwddata2
  );
endinterface

// File: rtl/regfile_wb_queue_fifo.sv
// rtl/regfile_wb_queue_fifo.sv - DEPTH-entry writeback FIFO exporting per-slot valid/rd for hazard lookup (REGFILE_BYPASS_EN adds slot data export)
import regfile_wb_queue_pkg::*;

module regfile_wb_queue_fifo (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push_i,
  input  logic                        pop_i,
  input  logic                        flush_i,
  input  wb_entry_t                   wr_entry_i,
  output wb_entry_t                   head_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic [PW-1:0]               rd_ptr_o,
  output logic [DEPTH-1:0]            valid_o,
  output logic [DEPTH-1:0][AW-1:0]    entry_rd_o
`ifdef REGFILE_BYPASS_EN
  ,
  output logic [DEPTH-1:0][XLEN-1:0]  entry_data_o
`endif
);

  wb_entry_t [DEPTH-1:0] mem_q;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;

  // Pointer/count update; flush wins over any push or pop in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; a flush cancels the write so stale data never appears valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= wr_entry_i;
    end
  end

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      valid_o[i]    = ({1'b0, PW'(i) - rd_ptr_q} < count_q);
      entry_rd_o[i] = mem_q[i].rd;
`ifdef REGFILE_BYPASS_EN
      entry_data_o[i] = mem_q[i].data;
`endif
    end
  end

  assign head_o   = mem_q[rd_ptr_q];
  assign full_o   = (count_q == CW'(DEPTH));
  assign empty_o  = (count_q == '0);
  assign rd_ptr_o = rd_ptr_q;

endmodule

// File: rtl/regfile_wb_queue.sv
// rtl/regfile_wb_queue.sv - writeback queue feeding the register file write port; REGFILE_BYPASS_EN enables youngest-entry forwarding
import regfile_wb_queue_pkg::*;

module regfile_wb_queue (
  input  logic               clk,
  input  logic               rst_n,
  regfile_wb_queue_if.slave  bus
);

  wb_entry_t               wr_entry;
  wb_entry_t               head;
  logic                    full, empty;
  logic                    push, pop;
  logic [PW-1:0]           rd_ptr;
  logic [DEPTH-1:0]        valid;
  logic [DEPTH-1:0][AW-1:0] entry_rd;

  logic [AW-1:0]           rd_q;
  logic [XLEN-1:0]         writedata_q;
  logic                    regwrite_q;

  // x0 requests complete the handshake but are never stored; flush discards a same-cycle push.
  assign push = bus.invalid && bus.inready && (bus.inrd != REG_ZERO) && !bus.flush;
  assign pop  = !empty && !bus.wrstall && !bus.flush;

  assign wr_entry.rd   = bus.inrd;
  assign wr_entry.data = bus.indata;

`ifdef REGFILE_BYPASS_EN
  logic [DEPTH-1:0][XLEN-1:0] entry_data;
`endif

  regfile_wb_queue_fifo u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (push),
    .pop_i        (pop),
    .flush_i      (bus.flush),
    .wr_entry_i   (wr_entry),
    .head_o       (head),
    .full_o       (full),
    .empty_o      (empty),
    .rd_ptr_o     (rd_ptr),
    .valid_o      (valid),
    .entry_rd_o   (entry_rd)
`ifdef REGFILE_BYPASS_EN
    ,
    .entry_data_o (entry_data)
`endif
  );

  // inready depends only on occupancy: a full queue never accepts, even while popping.
  assign bus.inready = !full;

  // Issue register: head moves to the write port; rd/writedata hold when nothing issues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q        <= '0;
      writedata_q <= '0;
      regwrite_q  <= 1'b0;
    end else if (pop) begin
      rd_q        <= head.rd;
      writedata_q <= head.data;
      regwrite_q  <= 1'b1;
    end else begin
      regwrite_q  <= 1'b0;
    end
  end

  assign bus.rd        = rd_q;
  assign bus.writedata = writedata_q;
  assign bus.regwrite  = regwrite_q;

  // Hazard lookup over live entries, oldest to youngest; the head being issued still counts.
  logic            busy1, busy2;
  logic [PW-1:0]   slot;
  always_comb begin
    busy1 = 1'b0;
    busy2 = 1'b0;
    slot  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = rd_ptr + PW'(k);
      if (valid[slot] && (bus.rs1 != REG_ZERO) && (entry_rd[slot] == bus.rs1)) busy1 = 1'b1;
      if (valid[slot] && (bus.rs2 != REG_ZERO) && (entry_rd[slot] == bus.rs2)) busy2 = 1'b1;
    end
  end

  assign bus.busy1 = busy1;
  assign bus.busy2 = busy2;

`ifdef REGFILE_BYPASS_EN
  logic            fv1, fv2;
  logic [XLEN-1:0] fd1, fd2;
  logic [PW-1:0]   fslot;
  // Forwarding walks oldest to youngest so the newest matching entry overwrites older hits.
  always_comb begin
    fv1   = 1'b0;
    fv2   = 1'b0;
    fd1   = '0;
    fd2   = '0;
    fslot = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fslot = rd_ptr + PW'(k);
      if (valid[fslot] && (bus.rs1 != REG_ZERO) && (entry_rd[fslot] == bus.rs1)) begin
        fv1 = 1'b1;
        fd1 = entry_data[fslot];
      end
      if (valid[fslot] && (bus.rs2 != REG_ZERO) && (entry_rd[fslot] == bus.rs2)) begin
        fv2 = 1'b1;
        fd2 = entry_data[fslot];
      end
    end
  end
  assign bus.fwdvalid1 = fv1;
  assign bus.fwdvalid2 = fv2;
  assign bus.fwddata1  = fd1;
  assign bus.fwddata2  = fd2;
`else
  assign bus.fwdvalid1 = 1'b0;
  assign bus.fwdvalid2 = 1'b0;
  assign bus.fwddata1  = '0;
  assign bus.fwddata2  = '0;
`endif

endmodule
